// File: rtl/obi_cmd_manager.sv
// OBI manager: FIFO-queued commands, one outstanding OBI transaction.
// Optional response timeout when OBI_CMD_MANAGER_TIMEOUT_EN is defined.
package obi_cmd_manager_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } obi_a_t;

  typedef struct packed {
    obi_a_t a;
    logic   req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        rid;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;
endpackage

module obi_cmd_manager #(
  parameter type obi_req_t = obi_cmd_manager_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_cmd_manager_pkg::obi_rsp_t,
  parameter int  CmdFifoDepth = 2,
  parameter int  TimeoutCycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i
);

  localparam int AW = $clog2(CmdFifoDepth);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  cmd_t          r_mem [CmdFifoDepth];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_aid;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_gnt;
  logic w_match;
  logic w_tmo;
  cmd_t w_head;
  cmd_t w_cmd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(CmdFifoDepth));
  assign w_gnt   = obi_rsp_i.gnt;
  assign w_pop   = (r_state == REQ) && w_gnt;
  // A full FIFO still accepts when its head leaves on this edge
  assign cmd_ready_o = !w_full || w_pop;
  assign w_push  = cmd_valid_i && cmd_ready_o;
  assign w_head  = r_mem[r_rptr];
  assign busy_o  = !w_empty || (r_state != IDLE);

  assign w_cmd.we    = cmd_we_i;
  assign w_cmd.addr  = cmd_addr_i;
  assign w_cmd.wdata = cmd_wdata_i;
  assign w_cmd.be    = cmd_be_i;

  // r_aid already toggled at grant, so the live tag is its complement
  assign w_match = (r_state == WAIT)
                && obi_rsp_i.rvalid
                && (obi_rsp_i.r.rid == ~r_aid);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_cmd;
  end

`ifdef OBI_CMD_MANAGER_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);

  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo <= '0;
    end else if (w_pop) begin
      r_tmo <= TW'(1);
    end else if (r_state == WAIT) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_tmo = (r_state == WAIT) && !w_match
              && (r_tmo >= TW'(TimeoutCycles - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aid   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop) r_aid <= ~r_aid;
      if (w_match) begin
        r_rdata <= obi_rsp_i.r.rdata;
        r_err   <= obi_rsp_i.r.err;
      end else if (w_tmo) begin
        r_rdata <= 32'hBADCAB1E;
        r_err   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (!w_empty) w_next = REQ;
      REQ:  if (w_gnt) w_next = WAIT;
      WAIT: if (w_match || w_tmo) w_next = RESP;
      RESP: if (rsp_ready_i) w_next = w_empty ? IDLE : REQ;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    obi_req_o   = '0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (r_state == REQ) begin
      obi_req_o.req     = 1'b1;
      obi_req_o.a.addr  = w_head.addr;
      obi_req_o.a.we    = w_head.we;
      obi_req_o.a.be    = w_head.be;
      obi_req_o.a.wdata = w_head.wdata;
      obi_req_o.a.aid   = r_aid;
    end
    if (r_state == RESP) begin
      rsp_valid_o = 1'b1;
      rsp_rdata_o = r_rdata;
      rsp_err_o   = r_err;
    end
  end

endmodule

// File: tb/tb_obi_cmd_manager.sv
// Directed + random bench for obi_cmd_manager with a transaction-level model.
// Timeout checks apply when OBI_CMD_MANAGER_TIMEOUT_EN is defined.
module tb_obi_cmd_manager;
  import obi_cmd_manager_pkg::*;

  localparam int Depth = 2;
  localparam int Tmo   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;

  obi_cmd_manager #(
    .obi_req_t    (obi_req_t),
    .obi_rsp_t    (obi_rsp_t),
    .CmdFifoDepth (Depth),
    .TimeoutCycles(Tmo)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_addr_i (cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .cmd_be_i   (cmd_be),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model state
  cmd_t        q[$];
  bit          inflight;
  bit          rsp_avail;
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          prev_occ;
  int          n_grant;
  int          n_push;
  int          wait_k;
`ifdef OBI_CMD_MANAGER_TIMEOUT_EN
  logic        stale_tag;
`endif

  // responder state
  bit          pend;
  logic        pend_tag;
  int          pend_dly;
  logic [31:0] pend_data;
  logic        pend_err;

  // knobs
  bit          rand_cmd;
  bit          chk_en;
  bit          no_resp;
  bit          rst_req;
  bit          fix_en;
  logic [31:0] fix_data;
  bit          d_valid;
  cmd_t        d_cmd;
  bit          inj;
  logic        inj_rid;
  int          gnt_pct;
  int          rdy_pct;
  int          noise_pct;
  int          min_dly;
  int          max_dly;

  task automatic step();
    bit   match_now;
    bit   granted;
    bit   exp_req;
    bit   exp_rdy;
    int   occ;
    cmd_t c;
    @(posedge clk);
    #1;
    match_now = 1'b0;
    granted   = 1'b0;
    rst = rst_req;
    if (rand_cmd) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      c.we    = 1'($urandom_range(0, 1));
      c.addr  = $urandom;
      c.wdata = $urandom;
      c.be    = 4'($urandom_range(0, 15));
    end else begin
      cmd_valid = d_valid;
      c = d_cmd;
    end
    cmd_we    = c.we;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_be    = c.be;
    obi_rsp.gnt = ($urandom_range(0, 99) < gnt_pct);
    rsp_ready   = ($urandom_range(0, 99) < rdy_pct);
    obi_rsp.rvalid = 1'b0;
    obi_rsp.r      = '0;
    if (pend && !no_resp && pend_dly == 0) begin
      obi_rsp.rvalid  = 1'b1;
      obi_rsp.r.rid   = pend_tag;
      obi_rsp.r.rdata = pend_data;
      obi_rsp.r.err   = pend_err;
      match_now = 1'b1;
      pend = 1'b0;
    end else begin
      if (pend && pend_dly > 0) pend_dly--;
      if (inj) begin
        obi_rsp.rvalid  = 1'b1;
        obi_rsp.r.rid   = inj_rid;
        obi_rsp.r.rdata = $urandom;
        obi_rsp.r.err   = 1'b1;
      end else if ($urandom_range(0, 99) < noise_pct) begin
        obi_rsp.rvalid  = 1'b1;
        obi_rsp.r.rid   = pend ? ~pend_tag : 1'($urandom_range(0, 1));
        obi_rsp.r.rdata = $urandom;
        obi_rsp.r.err   = 1'($urandom_range(0, 1));
      end
    end

    @(negedge clk);
    occ     = q.size();
    exp_req = !inflight && (prev_occ > 0);
    exp_rdy = (occ < Depth) || (exp_req && obi_rsp.gnt);
    if (chk_en) begin
      check("req", 128'(obi_req.req), 128'(exp_req));
      if (exp_req && occ > 0) begin
        check("a_addr", 128'(obi_req.a.addr), 128'(q[0].addr));
        check("a_we", 128'(obi_req.a.we), 128'(q[0].we));
        check("a_be", 128'(obi_req.a.be), 128'(q[0].be));
        check("a_wdata", 128'(obi_req.a.wdata), 128'(q[0].wdata));
        check("a_aid", 128'(obi_req.a.aid), 128'(n_grant[0]));
      end else begin
        check("a_idle", 128'(obi_req.a), 128'(0));
      end
      check("cmd_ready", 128'(cmd_ready), 128'(exp_rdy));
      check("busy", 128'(busy), 128'((occ > 0) || inflight));
      check("rsp_valid", 128'(rsp_valid), 128'(rsp_avail));
      if (rsp_avail) begin
        check("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
        check("rsp_err", 128'(rsp_err), 128'(exp_err));
      end
    end

    if (rst_req) begin
      q.delete();
      inflight  = 1'b0;
      rsp_avail = 1'b0;
      prev_occ  = 0;
      n_grant   = 0;
      pend      = 1'b0;
      wait_k    = 0;
    end else begin
      prev_occ = occ;
      if (cmd_valid && exp_rdy) begin
        q.push_back(c);
        n_push++;
      end
      if (exp_req && obi_rsp.gnt && q.size() > 0) begin
        void'(q.pop_front());
        granted   = 1'b1;
        inflight  = 1'b1;
        pend      = 1'b1;
        pend_tag  = n_grant[0];
        n_grant++;
        pend_dly  = $urandom_range(min_dly, max_dly);
        pend_data = fix_en ? fix_data : $urandom;
        pend_err  = fix_en ? 1'b0 : 1'($urandom_range(0, 1));
        wait_k    = 0;
      end
      if (rsp_avail && rsp_ready) begin
        rsp_avail = 1'b0;
        inflight  = 1'b0;
      end
      if (match_now) begin
        rsp_avail = 1'b1;
        exp_rdata = obi_rsp.r.rdata;
        exp_err   = obi_rsp.r.err;
      end
`ifdef OBI_CMD_MANAGER_TIMEOUT_EN
      else if (inflight && !rsp_avail && !granted) begin
        wait_k++;
        if (wait_k == Tmo - 1) begin
          rsp_avail = 1'b1;
          exp_rdata = 32'hBADCAB1E;
          exp_err   = 1'b1;
          stale_tag = pend_tag;
          pend      = 1'b0;
        end
      end
`endif
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !inflight) break;
      step();
    end
    step();
    check("drain_busy", 128'(busy), 128'(0));
  endtask

  task automatic defaults();
    rand_cmd  = 1'b0;
    d_valid   = 1'b0;
    gnt_pct   = 100;
    rdy_pct   = 100;
    noise_pct = 0;
    min_dly   = 0;
    max_dly   = 0;
    no_resp   = 1'b0;
    fix_en    = 1'b0;
    inj       = 1'b0;
    rst_req   = 1'b0;
  endtask

  initial begin
    logic old_tag;
    d_cmd     = '0;
    fix_data  = '0;
    inj_rid   = 1'b0;
    n_push    = 0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_be    = '0;
    rsp_ready = 1'b0;
    obi_rsp   = '0;
    defaults();
    chk_en  = 1'b0;
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    chk_en  = 1'b1;

    // reset state
    step();
    check("rst_rdata", 128'(rsp_rdata), 128'(0));
    check("rst_err", 128'(rsp_err), 128'(0));
    check("rst_ready", 128'(cmd_ready), 128'(1));

    // latency: write addr 0, wdata 1, be F
    fix_en   = 1'b1;
    fix_data = 32'h1234_5678;
    d_valid  = 1'b1;
    d_cmd    = '{we: 1'b1, addr: 32'h0, wdata: 32'h1, be: 4'hF};
    step();
    d_valid = 1'b0;
    step();
    check("lat_c1_req", 128'(obi_req.req), 128'(0));
    step();
    check("lat_c2_req", 128'(obi_req.req), 128'(1));
    step();
    check("lat_c3_rsp", 128'(rsp_valid), 128'(0));
    step();
    check("lat_c4_rsp", 128'(rsp_valid), 128'(1));
    check("lat_c4_err", 128'(rsp_err), 128'(0));
    check("lat_c4_wr_rdata", 128'(rsp_rdata), 128'(32'h1234_5678));
    drain();

    // read 0xC, response held while not consumed
    fix_data = 32'hDEADBEEF;
    rdy_pct  = 0;
    d_valid  = 1'b1;
    d_cmd    = '{we: 1'b0, addr: 32'hC, wdata: 32'h0, be: 4'hF};
    step();
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("hold_valid", 128'(rsp_valid), 128'(1));
      check("hold_rdata", 128'(rsp_rdata), 128'(32'hDEADBEEF));
    end
    rdy_pct = 100;
    fix_en  = 1'b0;
    drain();

    // grant withheld for 3 cycles
    gnt_pct = 0;
    d_valid = 1'b1;
    d_cmd   = '{we: 1'b1, addr: 32'h40, wdata: 32'hCAFE_F00D, be: 4'h6};
    step();
    d_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", 128'(obi_req.req), 128'(1));
      check("stall_addr", 128'(obi_req.a.addr), 128'(32'h40));
      check("stall_wdata", 128'(obi_req.a.wdata), 128'(32'hCAFE_F00D));
      check("stall_be", 128'(obi_req.a.be), 128'(4'h6));
    end
    gnt_pct = 100;
    step();
    step();
    check("wait_req", 128'(obi_req.req), 128'(0));
    check("wait_busy", 128'(busy), 128'(1));
    drain();

    // fill the FIFO while the subordinate stalls
    gnt_pct = 0;
    max_dly = 2;
    begin
      int target;
      target  = n_push + 3;
      d_valid = 1'b1;
      d_cmd   = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF};
      step();
      d_cmd   = '{we: 1'b1, addr: 32'h104, wdata: 32'h11, be: 4'h3};
      step();
      d_cmd   = '{we: 1'b0, addr: 32'h108, wdata: 32'h0, be: 4'hC};
      step();
      check("full_ready", 128'(cmd_ready), 128'(0));
      step();
      gnt_pct = 100;
      for (int i = 0; i < 20; i++) begin
        if (n_push >= target) break;
        step();
      end
      check("full_all_pushed", 128'(n_push >= target), 128'(cmd_ready !== 1'bx));
      d_valid = 1'b0;
    end
    max_dly = 0;
    drain();

    // subordinate never answers
    rdy_pct   = 0;
    no_resp   = 1'b1;
    noise_pct = 30;
    d_valid   = 1'b1;
    d_cmd     = '{we: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'hF};
    step();
    d_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("tmo_early", 128'(rsp_valid), 128'(0));
    step();
`ifdef OBI_CMD_MANAGER_TIMEOUT_EN
    check("tmo_valid", 128'(rsp_valid), 128'(1));
    check("tmo_rdata", 128'(rsp_rdata), 128'(32'hBADCAB1E));
    check("tmo_err", 128'(rsp_err), 128'(1));
    noise_pct = 0;
    no_resp   = 1'b0;
    rdy_pct   = 100;
    inj       = 1'b1;
    inj_rid   = stale_tag;
    min_dly   = 2;
    max_dly   = 2;
    d_valid   = 1'b1;
    d_cmd     = '{we: 1'b0, addr: 32'h204, wdata: 32'h0, be: 4'hF};
    step();
    d_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    inj     = 1'b0;
    min_dly = 0;
    max_dly = 0;
`else
    check("no_tmo_valid", 128'(rsp_valid), 128'(0));
    check("no_tmo_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 20; i++) step();
    noise_pct = 0;
    no_resp   = 1'b0;
    rdy_pct   = 100;
`endif
    drain();

    // reset while waiting for a response
    no_resp = 1'b1;
    d_valid = 1'b1;
    d_cmd   = '{we: 1'b1, addr: 32'h300, wdata: 32'h77, be: 4'hF};
    step();
    d_valid = 1'b0;
    step();
    step();
    old_tag = pend_tag;
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    check("rstw_busy", 128'(busy), 128'(0));
    check("rstw_ready", 128'(cmd_ready), 128'(1));
    check("rstw_valid", 128'(rsp_valid), 128'(0));
    no_resp = 1'b0;
    inj     = 1'b1;
    inj_rid = old_tag;
    for (int i = 0; i < 4; i++) step();
    inj = 1'b0;
    drain();

    // random traffic
    rand_cmd  = 1'b1;
    gnt_pct   = 60;
    rdy_pct   = 60;
    noise_pct = 15;
    max_dly   = 3;
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(0, 299) == 0);
      step();
    end
    defaults();
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
